// File: rtl/wfg_stim_ramp_pkg.sv
// Ramp stimulus shared definitions.
// Register offsets, control bits, state and mode types.
`timescale 1ns/1ps
package wfg_stim_ramp_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_START = 2'd1;
  localparam logic [1:0] REG_END   = 2'd2;
  localparam logic [1:0] REG_INC   = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  typedef enum logic {
    SAW = 1'b0,
    TRI = 1'b1
  } mode_t;

endpackage

// File: rtl/wfg_stim_ramp_wishbone_reg.sv
// Ramp stimulus Wishbone slave and register file.
// One-cycle ack; read data is the pre-write register value.
`timescale 1ns/1ps
module wfg_stim_ramp_wishbone_reg
  import wfg_stim_ramp_pkg::*;
#(
  parameter int BUSW = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BUSW-1:0] wbs_dat_i,
  input  logic [BUSW-1:0] wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [BUSW-1:0] wbs_dat_o,
  output logic            o_en,
  output mode_t           o_mode,
  output logic [BUSW-1:0] o_start,
  output logic [BUSW-1:0] o_end,
  output logic [BUSW-1:0] o_inc
);

  logic            r_ack;
  logic [BUSW-1:0] r_dat;
  logic            r_en;
  mode_t           r_mode;
  logic [BUSW-1:0] r_start;
  logic [BUSW-1:0] r_end;
  logic [BUSW-1:0] r_inc;

  logic [1:0]      w_adr;
  logic            w_req;
  logic [BUSW-1:0] w_rdata;
  logic            w_unused;

  assign w_adr = wbs_adr_i[3:2];
  assign w_req = wbs_stb_i & wbs_cyc_i & ~r_ack;

  // Byte selects and undecoded address bits have no effect.
  assign w_unused = ^{wbs_sel_i,
                      wbs_adr_i[BUSW-1:4],
                      wbs_adr_i[1:0]};

  // Select the addressed register for readback.
  always_comb begin
    w_rdata = '0;
    case (w_adr)
      REG_CTRL: begin
        w_rdata[CTRL_EN]   = r_en;
        w_rdata[CTRL_MODE] = r_mode;
      end
      REG_START: w_rdata = r_start;
      REG_END:   w_rdata = r_end;
      REG_INC:   w_rdata = r_inc;
      default:   w_rdata = '0;
    endcase
  end

  // Acknowledge, capture read data and perform writes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_en    <= 1'b0;
      r_mode  <= SAW;
      r_start <= '0;
      r_end   <= '0;
      r_inc   <= '0;
    end else begin
      r_ack <= 1'b0;
      if (w_req) begin
        r_ack <= 1'b1;
        r_dat <= w_rdata;
        if (wbs_we_i) begin
          case (w_adr)
            REG_CTRL: begin
              r_en   <= wbs_dat_i[CTRL_EN];
              r_mode <= mode_t'(wbs_dat_i[CTRL_MODE]);
            end
            REG_START: r_start <= wbs_dat_i;
            REG_END:   r_end   <= wbs_dat_i;
            REG_INC:   r_inc   <= wbs_dat_i;
            default:   r_inc   <= r_inc;
          endcase
        end
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign o_en      = r_en;
  assign o_mode    = r_mode;
  assign o_start   = r_start;
  assign o_end     = r_end;
  assign o_inc     = r_inc;

endmodule

// File: rtl/wfg_stim_ramp_top.sv
// Ramp stimulus generator: sawtooth or triangle samples
// on an AXI-Stream source, configured over Wishbone.
`timescale 1ns/1ps
module wfg_stim_ramp_top
  import wfg_stim_ramp_pkg::*;
#(
  parameter int BUSW = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BUSW-1:0] wbs_dat_i,
  input  logic [BUSW-1:0] wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [BUSW-1:0] wbs_dat_o,
  input  logic            wfg_axis_tready_i,
  output logic            wfg_axis_tvalid_o,
  output logic [BUSW-1:0] wfg_axis_tdata_o
);

  logic            w_en;
  mode_t           w_mode;
  logic [BUSW-1:0] w_start;
  logic [BUSW-1:0] w_end;
  logic [BUSW-1:0] w_inc;

  state_t          r_state;
  logic            r_tvalid;
  logic [BUSW-1:0] r_tdata;

  logic [BUSW:0]   w_sum;
  logic [BUSW:0]   w_dif;
  logic            w_flat;
  logic            w_saw;
  logic            w_down;
  logic            w_up;
  logic [BUSW-1:0] w_nxt_data;
  state_t          w_nxt_state;

  wfg_stim_ramp_wishbone_reg #(
    .BUSW (BUSW)
  ) u_reg (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .o_en      (w_en),
    .o_mode    (w_mode),
    .o_start   (w_start),
    .o_end     (w_end),
    .o_inc     (w_inc)
  );

  // Wide arithmetic exposes carry/borrow instead of wrapping.
  assign w_sum = {1'b0, r_tdata} + {1'b0, w_inc};
  assign w_dif = {1'b0, r_tdata} - {1'b0, w_inc};

  assign w_flat = (w_start >= w_end);
  assign w_saw  = ~w_flat & (w_mode == SAW);
  assign w_down = ~w_flat & (w_mode == TRI) & (r_state == DOWN);
  assign w_up   = ~w_flat & (w_mode == TRI) & (r_state != DOWN);

  // Compute the sample that follows the one currently held.
  always_comb begin
    w_nxt_data  = w_start;
    w_nxt_state = UP;
    unique case (1'b1)
      w_flat: begin
        w_nxt_data  = w_start;
        w_nxt_state = UP;
      end
      w_saw: begin
        w_nxt_state = UP;
        if (w_sum[BUSW] || (w_sum[BUSW-1:0] > w_end))
          w_nxt_data = w_start;
        else
          w_nxt_data = w_sum[BUSW-1:0];
      end
      w_up: begin
        if (w_sum[BUSW] || (w_sum[BUSW-1:0] >= w_end)) begin
          w_nxt_data  = w_end;
          w_nxt_state = DOWN;
        end else begin
          w_nxt_data  = w_sum[BUSW-1:0];
          w_nxt_state = UP;
        end
      end
      w_down: begin
        if (w_dif[BUSW] || (w_dif[BUSW-1:0] <= w_start)) begin
          w_nxt_data  = w_start;
          w_nxt_state = UP;
        end else begin
          w_nxt_data  = w_dif[BUSW-1:0];
          w_nxt_state = DOWN;
        end
      end
      default: begin
        w_nxt_data  = w_start;
        w_nxt_state = UP;
      end
    endcase
  end

  // Sequencer: start on enable, advance on each handshake.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else if (!w_en) begin
      r_state  <= IDLE;
      r_tvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tdata  <= w_start;
          r_tvalid <= 1'b1;
          r_state  <= UP;
        end
        UP, DOWN: begin
          if (r_tvalid && wfg_axis_tready_i) begin
            r_tdata <= w_nxt_data;
            r_state <= w_nxt_state;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tvalid <= 1'b0;
        end
      endcase
    end
  end

  assign wfg_axis_tvalid_o = r_tvalid;
  assign wfg_axis_tdata_o  = r_tdata;

endmodule

// File: tb/tb_wfg_stim_ramp_top.sv
// Testbench for the ramp stimulus generator.
// Random configurations checked against a sequence model.
`timescale 1ns/1ps
module tb_wfg_stim_ramp_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;

  int total = 0;
  int bad   = 0;

  longint m_cur, m_s, m_e, m_i;
  bit     m_tri, m_down;

  wfg_stim_ramp_top #(.BUSW(32)) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .wbs_stb_i         (stb),
    .wbs_cyc_i         (cyc),
    .wbs_we_i          (we),
    .wbs_sel_i         (sel),
    .wbs_dat_i         (dat_i),
    .wbs_adr_i         (adr),
    .wbs_ack_o         (ack),
    .wbs_dat_o         (dat_o),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tdata_o  (tdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] r);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    chk("wb_ack_lat", n, 1);
    r = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, r);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'h0, r);
    chk(tag, r, exp);
  endtask

  // Next sample from the ramp rules, using unbounded integers.
  function automatic void model_step();
    longint nxt;
    if (m_s >= m_e) begin
      m_cur = m_s; m_down = 0;
    end else if (!m_tri) begin
      nxt = m_cur + m_i;
      m_cur = (nxt > m_e) ? m_s : nxt;
      m_down = 0;
    end else if (!m_down) begin
      nxt = m_cur + m_i;
      if (nxt >= m_e) begin m_cur = m_e; m_down = 1; end
      else m_cur = nxt;
    end else begin
      nxt = m_cur - m_i;
      if (nxt <= m_s) begin m_cur = m_s; m_down = 0; end
      else m_cur = nxt;
    end
  endfunction

  task automatic configure(input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] i, input bit t);
    tready = 1'b0;
    wr(32'h0, 32'h0);
    wr(32'h4, s);
    wr(32'h8, e);
    wr(32'hC, i);
    m_s = s; m_e = e; m_i = i; m_tri = t;
    m_cur = s; m_down = 0;
    wr(32'h0, {30'b0, t, 1'b1});
    chk("en_lat_valid0", {31'b0, tvalid}, 32'd0);
    @(negedge clk);
    chk("first_valid", {31'b0, tvalid}, 32'd1);
    chk("first_data", tdata, s);
  endtask

  task automatic stream(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      chk("s_valid", {31'b0, tvalid}, 32'd1);
      chk("s_data", tdata, m_cur[31:0]);
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tready) model_step();
      @(negedge clk);
    end
  endtask

  logic [31:0] saw_exp [7];
  logic [31:0] tri_exp [10];
  logic [31:0] r, held;
  logic [31:0] s, e, inc;

  initial begin
    saw_exp = '{10, 14, 18, 10, 14, 18, 10};
    tri_exp = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3};
    rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 4'hF;
    dat_i = 0; adr = 0; tready = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_valid", {31'b0, tvalid}, 0);
    chk("rst_data", tdata, 0);
    rst = 1'b0;
    rd(32'h0, 0, "rst_ctrl");
    rd(32'h4, 0, "rst_start");
    rd(32'h8, 0, "rst_end");
    rd(32'hC, 0, "rst_inc");
    wr(32'h0, 32'hFFFF_FFFF);
    rd(32'h0, 32'h3, "ctrl_mask");
    wr(32'h0, 32'h0);
    wr(32'h4, 32'h55);
    wb_xfer(1'b1, 32'h4, 32'h0, r);
    chk("rbw", r, 32'h55);
    @(negedge clk);
    chk("ack_drop", {31'b0, ack}, 0);

    // directed sawtooth, full throughput
    configure(10, 20, 4, 0);
    tready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("saw_valid", {31'b0, tvalid}, 1);
      chk("saw_data", tdata, saw_exp[k]);
      @(negedge clk);
    end

    // directed triangle with a backpressure stall
    configure(0, 10, 3, 1);
    tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("tri_data", tdata, tri_exp[k]);
      if (k == 4) begin
        tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_valid", {31'b0, tvalid}, 1);
          chk("bp_data", tdata, tri_exp[4]);
        end
        tready = 1'b1;
      end
      @(negedge clk);
    end

    // carry into bit 32 returns to start
    configure(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0);
    stream(4, 0);
    configure(5, 5, 3, 1);
    stream(4, 0);

    // randomized configurations and backpressure
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        s   = $urandom_range(0, 200);
        e   = $urandom_range(0, 300);
        inc = $urandom_range(0, 40);
      end else begin
        s   = 32'hFFFF_FF00 + $urandom_range(0, 32'h80);
        e   = 32'hFFFF_FF80 + $urandom_range(0, 32'h7F);
        inc = $urandom_range(0, 32'h60);
      end
      configure(s, e, inc, 1'($urandom_range(0, 1)));
      stream(60, 1);
    end

    // disable while stalled, then re-enable
    tready = 1'b0;
    held = tdata;
    chk("pre_dis_data", held, m_cur[31:0]);
    wr(32'h0, 32'h0);
    chk("dis_ack_valid", {31'b0, tvalid}, 1);
    @(negedge clk);
    chk("dis_valid", {31'b0, tvalid}, 0);
    chk("dis_hold", tdata, held);
    wr(32'h0, {30'b0, m_tri, 1'b1});
    @(negedge clk);
    chk("reen_valid", {31'b0, tvalid}, 1);
    chk("reen_data", tdata, m_s[31:0]);
    m_cur = m_s; m_down = 0;
    stream(20, 1);

    // asynchronous reset mid-stream
    tready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, tvalid}, 0);
    chk("arst_data", tdata, 0);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h0, 0, "arst_ctrl");
    rd(32'h4, 0, "arst_start");
    chk("arst_idle", {31'b0, tvalid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
